// File: rtl/spi_mem_master.sv
// spi_mem_master: SPI mode-0 master for a serial memory.
// A write sends 02, addr_hi, addr_lo, wdata_hi, wdata_lo. A read sends
// 03, addr_hi, addr_lo, 00, and MISO is captured only during the 00 byte.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/o_req_ready  request handshake (ready only in IDLE)
//   i_req_rw              1 = write, 0 = read
//   i_req_addr[15:0]      memory address
//   i_req_wdata[15:0]     write word (ignored for reads)
//   o_rsp_valid           one-cycle pulse when o_rsp_data is updated by a read
//   o_rsp_data[7:0]       last read byte, held until the next read
//   o_busy                high in every state except IDLE
//   o_sck, o_mosi, i_miso, o_cs_n  SPI pins
//
// state     | meaning
// IDLE      | waiting for a request, o_req_ready high
// CS_SETUP  | CS low, SCK low, first MOSI bit presented for one half bit
// SHIFT     | clocking the frame out, low half then high half per bit
// CS_HOLD   | SCK low for one half bit before releasing CS
// CS_GAP    | CS high for CS_IDLE_CLKS cycles; read response issued here
module spi_mem_master #(
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int CS_IDLE_CLKS      = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_rw,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic        o_busy,
  output logic        o_sck,
  output logic        o_mosi,
  input  logic        i_miso,
  output logic        o_cs_n
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CS_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_CS_HOLD  = 3'd3;
  localparam logic [2:0] ST_CS_GAP   = 3'd4;

  localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_HALF_BIT - 1);
  localparam logic [7:0] GAP_M1  = 8'(CS_IDLE_CLKS - 1);

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [39:0] shreg_q, shreg_d;
  logic        rw_q, rw_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        accept;
  logic [2:0]  last_byte;

  assign o_req_ready = (state_q == ST_IDLE) & ~i_rst;
  assign accept      = i_req_valid & o_req_ready;
  assign last_byte   = rw_q ? 3'd4 : 3'd3;

  assign o_busy      = (state_q != ST_IDLE) & ~i_rst;
  assign o_sck       = sck_q;
  assign o_mosi      = mosi_q;
  assign o_cs_n      = cs_n_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    shreg_d     = shreg_q;
    rw_d        = rw_q;
    cs_n_d      = cs_n_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rx_d        = rx_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_CS_SETUP;
          cnt_d   = HALF_M1;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          rw_d    = i_req_rw;
          // Frame is left-justified so the MSB of byte 0 always sits at bit 39.
          shreg_d = i_req_rw ? {8'h02, i_req_addr, i_req_wdata}
                             : {8'h03, i_req_addr, 16'h0000};
          cs_n_d  = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = shreg_d[39];
        end
      end

      ST_CS_SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_SHIFT;
          cnt_d   = HALF_M1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          cnt_d = HALF_M1;
          if (!sck_q) begin
            sck_d = 1'b1;
            // Only the dummy byte of a read carries slave data.
            if (!rw_q && byte_q == 3'd3) begin
              rx_d = {rx_q[6:0], i_miso};
            end
          end else begin
            sck_d   = 1'b0;
            shreg_d = shreg_q << 1;
            mosi_d  = shreg_q[38];
            if (bit_q == 3'd7) begin
              bit_d = 3'd0;
              if (byte_q == last_byte) begin
                state_d = ST_CS_HOLD;
              end else begin
                byte_d = byte_q + 3'd1;
              end
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
      end

      ST_CS_HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_CS_GAP;
          cnt_d   = GAP_M1;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          if (!rw_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rx_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_CS_GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      bit_q       <= 3'd0;
      byte_q      <= 3'd0;
      shreg_q     <= 40'd0;
      rw_q        <= 1'b0;
      cs_n_q      <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rx_q        <= 8'd0;
      rsp_data_q  <= 8'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shreg_q     <= shreg_d;
      rw_q        <= rw_d;
      cs_n_q      <= cs_n_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rx_q        <= rx_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_mem_master.sv
module tb_spi_mem_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, req_rw, miso, sel;
  logic [15:0] req_addr, req_wdata;
  logic        valid_a, valid_b;
  logic        ready_a, rsp_valid_a, busy_a, sck_a, mosi_a, cs_n_a;
  logic        ready_b, rsp_valid_b, busy_b, sck_b, mosi_b, cs_n_b;
  logic [7:0]  rsp_data_a, rsp_data_b;
  logic        m_ready, m_rsp_valid, m_busy, m_sck, m_mosi, m_cs_n;
  logic [7:0]  m_rsp_data;

  assign valid_a = req_valid & ~sel;
  assign valid_b = req_valid & sel;

  spi_mem_master #(.CLKS_PER_HALF_BIT(4), .CS_IDLE_CLKS(8)) u_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid_a), .o_req_ready(ready_a),
    .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_a), .o_rsp_data(rsp_data_a), .o_busy(busy_a),
    .o_sck(sck_a), .o_mosi(mosi_a), .i_miso(miso), .o_cs_n(cs_n_a));

  spi_mem_master #(.CLKS_PER_HALF_BIT(2), .CS_IDLE_CLKS(8)) u_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(valid_b), .o_req_ready(ready_b),
    .i_req_rw(req_rw), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid_b), .o_rsp_data(rsp_data_b), .o_busy(busy_b),
    .o_sck(sck_b), .o_mosi(mosi_b), .i_miso(miso), .o_cs_n(cs_n_b));

  always_comb begin
    m_ready     = sel ? ready_b     : ready_a;
    m_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    m_busy      = sel ? busy_b      : busy_a;
    m_sck       = sel ? sck_b       : sck_a;
    m_mosi      = sel ? mosi_b      : mosi_a;
    m_cs_n      = sel ? cs_n_b      : cs_n_a;
    m_rsp_data  = sel ? rsp_data_b  : rsp_data_a;
  end

  localparam int GAP = 8;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_rsp [2];

  typedef struct {
    logic [39:0] cap;
    int rises, cs_low, gap, rsp_cnt, rsp_pos, viol, first_rise, last_rise;
    bit timeout;
  } res_t;

  typedef struct {
    bit sel; bit rw;
    logic [15:0] addr; logic [15:0] wdata; logic [7:0] sb;
    logic [39:0] exp_mosi; int exp_rises; int exp_cs_low; int exp_rsp_cnt;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int half_of(bit s);
    return s ? 2 : 4;
  endfunction

  // Reference model: frame bytes, bit count and CS-low time from the frame rules.
  function automatic logic [39:0] model_mosi(bit rw, logic [15:0] a, logic [15:0] w);
    if (rw) return {8'h02, a[15:8], a[7:0], w[15:8], w[7:0]};
    return {8'h00, 8'h03, a[15:8], a[7:0], 8'h00};
  endfunction

  function automatic int model_bits(bit rw);
    return (rw ? 5 : 4) * 8;
  endfunction

  function automatic int model_cs_low(bit rw, int h);
    // setup half-bit + two half-bits per data bit + hold half-bit
    return h + model_bits(rw) * 2 * h + h;
  endfunction

  task automatic issue_req(input bit rw, input logic [15:0] a, input logic [15:0] w,
                           output bit to);
    int n;
    to = 0;
    n = 0;
    while (!m_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) to = 1;
    req_rw = rw; req_addr = a; req_wdata = w; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_rw = 1'($urandom); req_addr = 16'($urandom); req_wdata = 16'($urandom);
  endtask

  task automatic run_frame(input bit rw, input logic [15:0] a, input logic [15:0] w,
                           input logic [7:0] sb, input bit noise, output res_t r);
    bit prev_sck, prev_mosi, prev_cs_n, started, to;
    int n;
    r.cap = '0; r.rises = 0; r.cs_low = 0; r.gap = 0; r.rsp_cnt = 0;
    r.rsp_pos = -1; r.viol = 0; r.first_rise = 0; r.last_rise = 0; r.timeout = 0;
    issue_req(rw, a, w, to);
    r.timeout = to;
    prev_sck = 0; prev_mosi = 0; prev_cs_n = 1; started = 0;
    for (n = 0; n < 4000; n++) begin
      if (m_rsp_valid) begin
        r.rsp_cnt++;
        r.rsp_pos = (started && m_cs_n) ? r.gap : -2;
      end
      if (!m_cs_n) begin
        started = 1;
        r.cs_low++;
      end else if (started && m_busy) begin
        r.gap++;
      end
      if (m_sck && !prev_sck) begin
        if (r.rises == 0) r.first_rise = n;
        r.last_rise = n;
        r.rises++;
        r.cap = {r.cap[38:0], m_mosi};
      end
      if (!m_cs_n && !prev_cs_n && m_mosi !== prev_mosi && !(prev_sck && !m_sck)) r.viol++;
      if (m_cs_n && (m_mosi !== 1'b0 || m_sck !== 1'b0)) r.viol++;
      prev_sck = m_sck; prev_mosi = m_mosi; prev_cs_n = m_cs_n;
      if (started && m_ready) break;
      // Slave: dummy-byte bits of a read, noise everywhere else; changes only while SCK low.
      if (!m_sck) begin
        if (!rw && r.rises >= 24 && r.rises < 32) miso = sb[3'(31 - r.rises)];
        else miso = 1'($urandom);
      end
      if (noise) begin
        req_valid = !m_cs_n ? 1'($urandom) : 1'b0;
        req_addr  = 16'($urandom);
      end
      @(negedge clk);
    end
    if (n >= 4000) r.timeout = 1;
    req_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag, input res_t r, input bit rw,
                             input logic [39:0] e_mosi, input int e_rises,
                             input int e_cs_low, input int e_rsp_cnt);
    int h;
    h = half_of(sel);
    chk({tag, " timeout"}, r.timeout, 0);
    chk({tag, " mosi"}, r.cap, e_mosi);
    chk({tag, " sck_rises"}, r.rises, e_rises);
    chk({tag, " cs_low"}, r.cs_low, e_cs_low);
    chk({tag, " gap"}, r.gap, GAP);
    chk({tag, " pin_rules"}, r.viol, 0);
    chk({tag, " sck_period"}, r.last_rise - r.first_rise, (e_rises - 1) * 2 * h);
    chk({tag, " rsp_cnt"}, r.rsp_cnt, e_rsp_cnt);
    if (!rw) chk({tag, " rsp_pos"}, r.rsp_pos, 0);
    chk({tag, " rsp_data"}, m_rsp_data, exp_rsp[sel]);
  endtask

  initial begin
    res_t r;
    bit to;
    int falls, hi, rises, n;
    bit prev_cs, prev_sck;
    logic [39:0] cap2;
    logic [7:0] sb;
    logic [15:0] a, w;

    sel = 0; rst = 1; req_valid = 1; req_rw = 1; req_addr = 16'h1111;
    req_wdata = 16'h2222; miso = 0;
    exp_rsp[0] = 8'h00; exp_rsp[1] = 8'h00;

    // Reset state, with a request held high (must be void).
    repeat (3) @(negedge clk);
    chk("rst ready_a", ready_a, 0);
    chk("rst busy_a", busy_a, 0);
    chk("rst cs_n_a", cs_n_a, 1);
    chk("rst sck_a", sck_a, 0);
    chk("rst mosi_a", mosi_a, 0);
    chk("rst rsp_valid_a", rsp_valid_a, 0);
    chk("rst rsp_data_a", rsp_data_a, 0);
    chk("rst cs_n_b", cs_n_b, 1);
    chk("rst ready_b", ready_b, 0);
    rst = 0; req_valid = 0;
    @(negedge clk);
    chk("post_rst ready", ready_a, 1);
    chk("post_rst busy", busy_a, 0);
    chk("post_rst cs_n", cs_n_a, 1);

    // Vector table: directed entries first, then randomized ones from the model.
    vecs[0] = '{0, 1, 16'h1234, 16'hBEEF, 8'h00, 40'h021234BEEF, 40, 328, 0};
    vecs[1] = '{0, 0, 16'h00A5, 16'h0000, 8'h5A, 40'h000300A500, 32, 264, 1};
    vecs[2] = '{1, 0, 16'hFFFF, 16'h0000, 8'hC3, 40'h0003FFFF00, 32, 132, 1};
    for (int i = 3; i < NV; i++) begin
      vecs[i].sel   = 1'($urandom);
      vecs[i].rw    = 1'($urandom);
      vecs[i].addr  = 16'($urandom);
      vecs[i].wdata = 16'($urandom);
      vecs[i].sb    = 8'($urandom);
      vecs[i].exp_mosi    = model_mosi(vecs[i].rw, vecs[i].addr, vecs[i].wdata);
      vecs[i].exp_rises   = model_bits(vecs[i].rw);
      vecs[i].exp_cs_low  = model_cs_low(vecs[i].rw, half_of(vecs[i].sel));
      vecs[i].exp_rsp_cnt = vecs[i].rw ? 0 : 1;
    end

    for (int i = 0; i < NV; i++) begin
      sel = vecs[i].sel;
      @(negedge clk);
      run_frame(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].sb, 0, r);
      if (!vecs[i].rw) exp_rsp[vecs[i].sel] = vecs[i].sb;
      check_frame($sformatf("vec%0d", i), r, vecs[i].rw, vecs[i].exp_mosi,
                  vecs[i].exp_rises, vecs[i].exp_cs_low, vecs[i].exp_rsp_cnt);
    end

    // Back-to-back writes with valid held high.
    sel = 0;
    @(negedge clk);
    issue_req(1, 16'hA001, 16'h1357, to);
    req_valid = 1; req_rw = 1; req_addr = 16'hB002; req_wdata = 16'h2468;
    falls = 1; hi = 0; prev_cs = 0; prev_sck = 0; cap2 = '0;
    for (n = 0; n < 3000; n++) begin
      if (prev_cs && !m_cs_n) begin
        falls++;
        req_valid = 0;
      end
      if (m_cs_n && falls == 1) hi++;
      if (falls == 2 && m_sck && !prev_sck) cap2 = {cap2[38:0], m_mosi};
      prev_cs = m_cs_n; prev_sck = m_sck;
      if (falls == 2 && m_ready) break;
      @(negedge clk);
    end
    req_valid = 0;
    chk("b2b timeout", (n >= 3000), 0);
    chk("b2b frames", falls, 2);
    chk("b2b cs_gap_ge8", (hi >= GAP), 1);
    chk("b2b frame2 mosi", cap2, model_mosi(1, 16'hB002, 16'h2468));
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (!m_cs_n) hi++;
    end
    chk("b2b no third frame", hi, 0);

    // Requests pulsed during SHIFT are ignored.
    a = 16'($urandom); w = 16'($urandom);
    run_frame(1, a, w, 8'h00, 1, r);
    check_frame("noise", r, 1, model_mosi(1, a, w), 40, model_cs_low(1, 4), 0);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (!m_cs_n || m_busy) hi++;
    end
    chk("noise single frame", hi, 0);

    // Reset in the middle of byte 2 of a read.
    issue_req(0, 16'h4321, 16'h0000, to);
    rises = 0; prev_sck = 0;
    for (n = 0; n < 2000 && rises < 18; n++) begin
      if (m_sck && !prev_sck) rises++;
      prev_sck = m_sck;
      if (rises < 18) @(negedge clk);
    end
    chk("midrst reach byte2", rises, 18);
    rst = 1;
    @(negedge clk);
    chk("midrst cs_n", m_cs_n, 1);
    chk("midrst sck", m_sck, 0);
    chk("midrst mosi", m_mosi, 0);
    chk("midrst busy", m_busy, 0);
    chk("midrst ready", m_ready, 0);
    chk("midrst rsp_valid", m_rsp_valid, 0);
    chk("midrst rsp_data", m_rsp_data, 0);
    exp_rsp[0] = 8'h00; exp_rsp[1] = 8'h00;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("midrst ready after", m_ready, 1);
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (!m_cs_n || m_rsp_valid || m_sck) hi++;
    end
    chk("midrst no resume", hi, 0);
    sb = 8'($urandom);
    run_frame(0, 16'h0F0F, 16'h0000, sb, 0, r);
    exp_rsp[0] = sb;
    check_frame("after_rst", r, 0, model_mosi(0, 16'h0F0F, 16'h0000), 32,
                model_cs_low(0, 4), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
